debouncer: RTL and testbench

DEBOUNCER -- requirements
Module: debouncer

---
 rtl/debouncer.sv | 105 ++++++++++
 tb/tb_debouncer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer.sv
// Key-code debouncer: a key code is accepted only after it has been stable for
// DEBOUNCE_CYCLES clocks. Optional release debouncing via DEBOUNCER_RELEASE_DEBOUNCE_EN.
module debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 960000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sig_in,
    input  logic       key_pressed,
    output logic [3:0] sig_out,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_e;

    localparam logic [31:0] CYCLES  = 32'(DEBOUNCE_CYCLES);
    localparam logic [3:0]  NO_KEY  = 4'b1111;
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    state_e      state_q;
    logic [3:0]  sample_q;
    logic [3:0]  sig_out_q;
    logic [31:0] counter;
    logic        counter_done;
    logic [31:0] counter_inc;
    logic        sample_match;

    assign counter_done = (counter == CYCLES);
    // Saturating increment: the counter parks at its maximum instead of wrapping.
    assign counter_inc  = (counter == CNT_MAX) ? counter : counter + 32'd1;
    assign sample_match = (sig_in == sample_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            counter   <= 32'd0;
            sample_q  <= NO_KEY;
            sig_out_q <= NO_KEY;
        end else begin
            case (state_q)
                IDLE: begin
                    counter   <= 32'd0;
                    sig_out_q <= NO_KEY;
                    if (key_pressed) begin
                        sample_q <= sig_in;
                        state_q  <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    // Instability is tested first so it wins over a coincident counter_done.
                    if (!key_pressed || !sample_match) begin
                        counter <= 32'd0;
                        state_q <= IDLE;
                    end else if (counter_done) begin
                        sig_out_q <= sample_q;
                        counter   <= 32'd0;
                        state_q   <= PRESSED;
                    end else begin
                        counter <= counter_inc;
                    end
                end
                PRESSED: begin
                    counter <= 32'd0;
                    if (!key_pressed) begin
`ifdef DEBOUNCER_RELEASE_DEBOUNCE_EN
                        state_q   <= RELEASE_WAIT;
`else
                        sig_out_q <= NO_KEY;
                        state_q   <= IDLE;
`endif
                    end
                end
`ifdef DEBOUNCER_RELEASE_DEBOUNCE_EN
                RELEASE_WAIT: begin
                    if (key_pressed) begin
                        counter <= 32'd0;
                        state_q <= PRESSED;
                    end else if (counter_done) begin
                        sig_out_q <= NO_KEY;
                        counter   <= 32'd0;
                        state_q   <= IDLE;
                    end else begin
                        counter <= counter_inc;
                    end
                end
`endif
                default: begin
                    state_q   <= IDLE;
                    counter   <= 32'd0;
                    sample_q  <= NO_KEY;
                    sig_out_q <= NO_KEY;
                end
            endcase
        end
    end

    assign sig_out = sig_out_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer (DEBOUNCE_CYCLES = 20) against a run-length
// reference model; honours DEBOUNCER_RELEASE_DEBOUNCE_EN like the design.
module tb_debouncer;

    localparam int N = 20;
    localparam logic [3:0] NO_KEY = 4'b1111;

    logic       clk;
    logic       reset;
    logic [3:0] sig_in;
    logic       key_pressed;
    logic [3:0] sig_out;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    // Reference model: output level plus lengths of the current stable press / release runs.
    logic [3:0] m_out;
    logic [3:0] m_code;
    logic       m_held;
    int         m_run;
    int         m_low;

    debouncer #(.DEBOUNCE_CYCLES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .sig_in      (sig_in),
        .key_pressed (key_pressed),
        .sig_out     (sig_out),
        .state_o     (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_edge(input logic rst, input logic key, input logic [3:0] code);
        if (rst) begin
            m_out  = NO_KEY;
            m_code = NO_KEY;
            m_held = 1'b0;
            m_run  = 0;
            m_low  = 0;
        end else if (!m_held) begin
            // A press is accepted once one code has been held for N+2 consecutive edges;
            // a broken run throws away that edge too, so the next run starts one edge later.
            if (m_run == 0) begin
                if (key) begin
                    m_run  = 1;
                    m_code = code;
                end
            end else if (!key || code != m_code) begin
                m_run = 0;
            end else begin
                m_run++;
                if (m_run == N + 2) begin
                    m_out  = m_code;
                    m_held = 1'b1;
                    m_run  = 0;
                    m_low  = 0;
                end
            end
        end else begin
`ifdef DEBOUNCER_RELEASE_DEBOUNCE_EN
            if (key) begin
                m_low = 0;
            end else begin
                m_low++;
                if (m_low == N + 2) begin
                    m_out  = NO_KEY;
                    m_held = 1'b0;
                    m_low  = 0;
                end
            end
`else
            if (!key) begin
                m_out  = NO_KEY;
                m_held = 1'b0;
            end
`endif
        end
    endtask

    // Applies one clock of stimulus; returns at the following falling edge.
    task automatic drive(input logic rst, input logic key, input logic [3:0] code);
        reset       = rst;
        key_pressed = key;
        sig_in      = code;
        @(posedge clk);
        model_edge(rst, key, code);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, NO_KEY);
        drive(1'b1, 1'b0, NO_KEY);
        checks++;
        if (sig_out !== NO_KEY) begin
            errors++;
            $display("FAIL reset_sig_out got=%b exp=%b", sig_out, NO_KEY);
        end
        checks++;
        if (state_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got=%0d exp=0", state_o);
        end
        checks++;
        if (dut.counter !== 32'd0) begin
            errors++;
            $display("FAIL reset_counter got=%0d exp=0", dut.counter);
        end
        drive(1'b0, 1'b0, NO_KEY);
    endtask

    task automatic test_clean_press();
        logic [3:0] want;
        drive(1'b1, 1'b0, NO_KEY);
        for (int i = 1; i <= 40; i++) begin
            drive(1'b0, 1'b1, 4'b1010);
            want = (i >= N + 2) ? 4'b1010 : NO_KEY;
            checks++;
            if (sig_out !== want || sig_out !== m_out) begin
                errors++;
                $display("FAIL clean_press cyc=%0d got=%b exp=%b model=%b", i, sig_out, want, m_out);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] want;
        drive(1'b1, 1'b0, NO_KEY);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, (i % 2 == 0), (i % 2 == 0) ? 4'b0101 : 4'b0000);
            checks++;
            if (sig_out !== NO_KEY) begin
                errors++;
                $display("FAIL bounce_phase cyc=%0d got=%b exp=%b", i, sig_out, NO_KEY);
            end
        end
        for (int i = 1; i <= 40; i++) begin
            drive(1'b0, 1'b1, 4'b0101);
            want = (i >= N + 2) ? 4'b0101 : NO_KEY;
            checks++;
            if (sig_out !== want || sig_out !== m_out) begin
                errors++;
                $display("FAIL bounce_settle cyc=%0d got=%b exp=%b model=%b", i, sig_out, want, m_out);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] want;
        drive(1'b1, 1'b0, NO_KEY);
        for (int i = 0; i < N + 4; i++) drive(1'b0, 1'b1, 4'b0011);
        // While held, code changes on sig_in must not reach the output.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 4'(i));
            checks++;
            if (sig_out !== 4'b0011) begin
                errors++;
                $display("FAIL held_ignores_code cyc=%0d got=%b exp=0011", i, sig_out);
            end
        end
`ifdef DEBOUNCER_RELEASE_DEBOUNCE_EN
        for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, NO_KEY);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 4'b0011);
        checks++;
        if (sig_out !== 4'b0011) begin
            errors++;
            $display("FAIL release_glitch got=%b exp=0011", sig_out);
        end
        for (int i = 1; i <= 40; i++) begin
            drive(1'b0, 1'b0, NO_KEY);
            want = (i >= N + 2) ? NO_KEY : 4'b0011;
            checks++;
            if (sig_out !== want || sig_out !== m_out) begin
                errors++;
                $display("FAIL release cyc=%0d got=%b exp=%b model=%b", i, sig_out, want, m_out);
            end
        end
`else
        drive(1'b0, 1'b0, NO_KEY);
        checks++;
        if (sig_out !== NO_KEY || sig_out !== m_out) begin
            errors++;
            $display("FAIL release_fast got=%b exp=%b", sig_out, NO_KEY);
        end
`endif
    endtask

    task automatic test_reset_midcount();
        logic [3:0] want;
        drive(1'b1, 1'b0, NO_KEY);
        for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, 4'b0110);
        checks++;
        if (dut.counter !== 32'd10) begin
            errors++;
            $display("FAIL midcount_counter got=%0d exp=10", dut.counter);
        end
        drive(1'b1, 1'b1, 4'b0110);
        checks++;
        if (sig_out !== NO_KEY || dut.counter !== 32'd0) begin
            errors++;
            $display("FAIL midcount_reset sig_out=%b counter=%0d exp=1111/0", sig_out, dut.counter);
        end
        for (int i = 1; i <= N + 2; i++) begin
            drive(1'b0, 1'b1, 4'b0110);
            want = (i == N + 2) ? 4'b0110 : NO_KEY;
            checks++;
            if (sig_out !== want) begin
                errors++;
                $display("FAIL midcount_recount cyc=%0d got=%b exp=%b", i, sig_out, want);
            end
        end
    endtask

    task automatic test_random();
        int         len;
        logic       key;
        logic [3:0] code;
        logic       rst;
        drive(1'b1, 1'b0, NO_KEY);
        code = 4'b1001;
        for (int seg = 0; seg < 120; seg++) begin
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 30);
            key = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(0, 15));
            for (int c = 0; c < len; c++) begin
                rst = ($urandom_range(0, 199) == 0);
                if ($urandom_range(0, 29) == 0) code = 4'($urandom_range(0, 15));
                drive(rst, key, code);
                checks++;
                if (sig_out !== m_out) begin
                    errors++;
                    $display("FAIL random seg=%0d cyc=%0d got=%b exp=%b", seg, c, sig_out, m_out);
                end
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        key_pressed = 1'b0;
        sig_in      = NO_KEY;
        model_edge(1'b1, 1'b0, NO_KEY);
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_reset_midcount();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
